fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register consumed by decode. It is the direct upstream neighbour of the load-use hazard detection unit. It honours that unit's PC-write and IF/ID-write enables, accepts branch/jump redirects resolved in ID, and inserts NOP bubbles on flush or halt. Saturating stall and flush counters support performance debug.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; low 2 bits must be 0.
- CNT_W, 16: width of the stall and flush performance counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- pc_wr_i  in  1  PC write enable from hazard detection; 0 = hold PC.
- if_id_wr_i  in  1  IF/ID write enable from hazard detection; 0 = hold IF/ID.
- redirect_i  in  1  taken branch or jump resolved in ID this cycle.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored and treated as 00.
- halt_i  in  1  halt request from ID.
- imem_addr_o  out  32  instruction-memory address; equals the PC register.
- imem_en_o  out  1  fetch enable; 0 in BOOT and HALTED.
- instr_i  in  32  instruction word; combinational from imem_addr_o in the same cycle.
- if_id_pc4_o  out  32  PC+4 of the instruction held in IF/ID.
- if_id_instr_o  out  32  instruction held in IF/ID; 32'h0 (NOP) when invalid.
- if_id_valid_o  out  1  IF/ID holds a real instruction.
- halted_o  out  1  FSM is in HALTED.
- stall_cnt_o  out  CNT_W  saturating count of cycles with if_id_wr_i=0 in RUN.
- flush_cnt_o  out  CNT_W  saturating count of accepted redirects.

## Operation
FSM states: BOOT, RUN, HALTED. Transitions:
- Reset enters BOOT.
- BOOT moves to RUN unconditionally after one cycle.
- RUN moves to HALTED on an accepted halt.
- HALTED exits only via reset.

Per-cycle priority in RUN:
1. Stall. If if_id_wr_i=0, IF/ID holds. PC holds iff pc_wr_i=0, and each register follows its own enable. Any redirect or halt this cycle is ignored, because ID re-evaluates it next cycle. stall_cnt increments.
2. Redirect (if_id_wr_i=1 and redirect_i=1). PC <= {redirect_pc_i[31:2],2'b00} regardless of pc_wr_i. IF/ID <= NOP, valid 0, pc4 0. flush_cnt increments.
3. Halt (if_id_wr_i=1, halt_i=1, redirect_i=0). IF/ID <= NOP. PC holds. Go to HALTED.
   - If halt_i and redirect_i are both asserted, the redirect wins and the halt is dropped.
4. Normal. IF/ID <= {instr_i, PC+4, valid 1}. PC <= PC+4 if pc_wr_i=1.

Other states:
- BOOT: PC holds at RESET_VECTOR, IF/ID stays NOP, and all inputs are ignored.
- HALTED: PC frozen, IF/ID forced to NOP, all inputs ignored.

Arithmetic and counters:
- PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Counters saturate at all-ones and never wrap.

## Timing
Reset values, one edge after rst_i=1:
- PC, and therefore imem_addr_o, = RESET_VECTOR.
- imem_en_o=0.
- if_id_instr_o=0, if_id_pc4_o=0, if_id_valid_o=0.
- halted_o=0.
- Both counters = 0.
- FSM = BOOT.

Reset asserted mid-stall, mid-redirect or while HALTED overrides everything on that edge.

Latency:
- The first valid fetch is at RESET_VECTOR in the cycle after BOOT.
- That instruction appears in IF/ID one edge later, so the first if_id_valid_o=1 is on the 3rd edge counted from the reset edge.
- A redirect accepted at edge N presents the target on imem_addr_o after N, and the target instruction is valid in IF/ID after N+1: exactly one bubble.
- A stall of k cycles holds IF/ID and the PC constant for k edges; no instruction is lost or duplicated.

All outputs are registered except imem_en_o, which decodes the FSM state.

## Structure
- Shared pipeline package holds NOP_INSTR (32'h0), the PC width constant (32), and the fetch FSM state enum (BOOT/RUN/HALTED).
- One sub-module, sat_counter (parameter CNT_W; inputs inc_i, clk_i, rst_i), instantiated twice for the stall and flush counters.
- The PC and the IF/ID register stay inline.

## Test plan
- Reset, then free run with instr_i = address+1: if_id_valid_o rises on the 3rd edge after reset. if_id_instr_o=1, pc4=4, then instr 5 with pc4=8, and so on.
- Load-use stall with pc_wr_i=if_id_wr_i=0 for 2 cycles while IF/ID holds instr at pc 8: IF/ID and imem_addr_o stay unchanged for 2 edges, the sequence then resumes with no gap, and stall_cnt_o=2.
- Redirect to 32'h0000_0103 in RUN: imem_addr_o=0x100 next cycle, one NOP bubble (valid 0) appears, and flush_cnt_o=1.
- Redirect and stall in the same cycle: redirect ignored, PC held, flush_cnt_o unchanged. Redirect repeated next cycle without stall: taken.
- Halt and redirect together: redirect taken, no halt. Halt alone: halted_o=1, imem_en_o=0, and IF/ID stays NOP through 10 cycles of varied inputs. rst_i then returns the PC to RESET_VECTOR.
- PC at 32'hFFFF_FFFC with normal fetch: next PC=0, and if_id_pc4_o=0. Counter preset near saturation via a long stall (CNT_W=4): stall_cnt_o stops at 15.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage_pkg
// Purpose : Shared pipeline definitions used by the instruction-fetch stage:
//           the NOP encoding, the PC width and the fetch FSM state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int          PC_W      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Saturating up-counter. Increments on inc_i and sticks at
//           all-ones instead of wrapping.
// Ports   : clk_i   clock
//           rst_i   synchronous active-high reset, clears the count
//           inc_i   increment request for this cycle
//           count_o current count (registered)
// Revision: 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (inc_i && (count != {CNT_W{1'b1}})) begin
      count <= count + ONE;
    end
  end

  assign count_o = count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : fetch_stage
// Purpose : Instruction-fetch stage. Owns the PC, drives the instruction
//           memory address, and holds the IF/ID pipeline register. Honours
//           the hazard unit's PC / IF/ID write enables, takes redirects
//           resolved in ID, inserts NOP bubbles on flush or halt, and keeps
//           saturating stall / flush counters for performance debug.
// Ports   : clk_i, rst_i          clock, synchronous active-high reset
//           pc_wr_i, if_id_wr_i   write enables from hazard detection
//           redirect_i/_pc_i      taken branch/jump and its target
//           halt_i                halt request from ID
//           imem_addr_o/_en_o     instruction memory address / enable
//           instr_i               instruction word for imem_addr_o
//           if_id_*_o             IF/ID register contents
//           halted_o              FSM is in HALTED
//           stall_cnt_o           stalled RUN cycles (saturating)
//           flush_cnt_o           accepted redirects (saturating)
// Revision: 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pc_wr_i,
  input  logic             if_id_wr_i,
  input  logic             redirect_i,
  input  logic [31:0]      redirect_pc_i,
  input  logic             halt_i,
  output logic [31:0]      imem_addr_o,
  output logic             imem_en_o,
  input  logic [31:0]      instr_i,
  output logic [31:0]      if_id_pc4_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  fetch_state_t    state, state_next;
  logic [PC_W-1:0] pc, pc_next;
  logic [31:0]     ifid_instr, ifid_instr_next;
  logic [PC_W-1:0] ifid_pc4, ifid_pc4_next;
  logic            ifid_valid, ifid_valid_next;
  logic            halted;
  logic            stall_inc, flush_inc;

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] redirect_target;

  // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 naturally.
  assign pc_plus4        = pc + 32'd4;
  // Targets are word aligned; the low two bits are masked off.
  assign redirect_target = redirect_pc_i & ~32'h0000_0003;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= BOOT;
      pc         <= RESET_VECTOR;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_instr <= ifid_instr_next;
      ifid_pc4   <= ifid_pc4_next;
      ifid_valid <= ifid_valid_next;
      halted     <= (state_next == HALTED);
    end
  end

  // --------------------------------------------------------------------------
  // Next-state / datapath decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ifid_instr_next = ifid_instr;
    ifid_pc4_next   = ifid_pc4;
    ifid_valid_next = ifid_valid;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;

    case (state)
      BOOT: begin
        // PC and IF/ID keep their reset values; inputs are ignored.
        state_next = RUN;
      end

      RUN: begin
        if (!if_id_wr_i) begin
          // Stall: redirect/halt are dropped because ID re-evaluates them
          // next cycle. The PC follows its own enable independently.
          stall_inc = 1'b1;
          if (pc_wr_i) begin
            pc_next = pc_plus4;
          end
        end else if (redirect_i) begin
          // Redirect beats halt and overrides pc_wr_i.
          pc_next         = redirect_target;
          ifid_instr_next = NOP_INSTR;
          ifid_pc4_next   = '0;
          ifid_valid_next = 1'b0;
          flush_inc       = 1'b1;
        end else if (halt_i) begin
          ifid_instr_next = NOP_INSTR;
          ifid_pc4_next   = '0;
          ifid_valid_next = 1'b0;
          state_next      = HALTED;
        end else begin
          ifid_instr_next = instr_i;
          ifid_pc4_next   = pc_plus4;
          ifid_valid_next = 1'b1;
          if (pc_wr_i) begin
            pc_next = pc_plus4;
          end
        end
      end

      HALTED: begin
        ifid_instr_next = NOP_INSTR;
        ifid_pc4_next   = '0;
        ifid_valid_next = 1'b0;
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_inc),
    .count_o (stall_cnt_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (flush_inc),
    .count_o (flush_cnt_o)
  );

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr_o   = pc;
  assign imem_en_o     = (state == RUN);
  assign if_id_pc4_o   = ifid_pc4;
  assign if_id_instr_o = ifid_instr;
  assign if_id_valid_o = ifid_valid;
  assign halted_o      = halted;

endmodule : fetch_stage
`default_nettype wire
